// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: state encoding,
// opcode constants, ALUOp codes, datapath mux encodings and error codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_R_EXEC    = 4'd3,
        ST_R_WB      = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_RD    = 4'd6,
        ST_LD_WB     = 4'd7,
        ST_MEM_WR    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_DONE      = 4'd13,
        ST_ERROR     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    // States that hold mem_req and therefore run the wait-state timer.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : FSM is in a memory state holding mem_req
//   mem_ready  : memory completes the access this cycle
//   timeout    : last allowed cycle reached with no mem_ready
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Every entry into a memory state comes from a non-memory state and every
    // exit follows mem_ready or a timeout, so clearing outside memory states
    // (or on completion) is the same as clearing on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || mem_ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign timeout = active && !mem_ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch, decode, execute, memory, writeback.
//   clk, rst_n       : clock, asynchronous active-low reset
//   run, opcode      : run level and IR[31:26]
//   zero, mem_ready  : ALU zero flag, memory completion
//   mem_req/mem_we/iord, ir_write, pc_write, pc_src : memory and PC control
//   alu_src_a/alu_src_b/alu_op/alu_funct_force     : ALU operand and op select
//   reg_write/reg_dst/mem_to_reg                   : register file writeback
//   retire, retired_cnt : retire pulse and running count (registered)
//   err              : sticky error cause; state_o : current state for debug
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             alu_funct_force,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [1:0]       err,
    output logic [3:0]       state_o
);

    state_t state;
    logic   timeout;
    logic   op_legal;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (is_mem_state(state)),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            err         <= ERR_NONE;
            retire      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            retire <= (state == ST_DONE);
            if (state == ST_DONE) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end

            // First cause wins; ERROR is absorbing so a second cause cannot occur
            // in practice, but the guard keeps err sticky regardless.
            if (err == ERR_NONE) begin
                if (timeout) begin
                    err <= ERR_TIMEOUT;
                end else if (state == ST_DECODE && !op_legal) begin
                    err <= ERR_ILLEGAL;
                end
            end

            case (state)
                ST_IDLE:      if (run) state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready)    state <= ST_DECODE;
                    else if (timeout) state <= ST_ERROR;
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state <= ST_R_EXEC;
                        OP_LW, OP_SW: state <= ST_MEM_ADDR;
                        OP_BEQ:       state <= ST_BRANCH;
                        OP_J:         state <= ST_JUMP;
                        OP_ADDI:      state <= ST_ADDI_EXEC;
                        default:      state <= ST_ERROR;
                    endcase
                end
                ST_R_EXEC:    state <= ST_R_WB;
                ST_R_WB:      state <= ST_DONE;
                ST_MEM_ADDR:  state <= (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: begin
                    if (mem_ready)    state <= ST_LD_WB;
                    else if (timeout) state <= ST_ERROR;
                end
                ST_LD_WB:     state <= ST_DONE;
                ST_MEM_WR: begin
                    if (mem_ready)    state <= ST_DONE;
                    else if (timeout) state <= ST_ERROR;
                end
                ST_BRANCH:    state <= ST_DONE;
                ST_JUMP:      state <= ST_DONE;
                ST_ADDI_EXEC: state <= ST_ADDI_WB;
                ST_ADDI_WB:   state <= ST_DONE;
                ST_DONE:      state <= run ? ST_FETCH : ST_IDLE;
                ST_ERROR:     state <= ST_ERROR;
                default:      state <= ST_ERROR;
            endcase
        end
    end

    // Controls decode from the state register; only FETCH (mem_ready) and
    // BRANCH (zero) qualify a strobe with a live input.
    always_comb begin
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        iord            = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_src          = PCSRC_ALU;
        alu_src_a       = 1'b0;
        alu_src_b       = SRCB_RT;
        alu_op          = ALUOP_FUNCT;
        alu_funct_force = 1'b0;
        reg_write       = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req         = 1'b1;
                alu_src_b       = SRCB_FOUR;
                alu_funct_force = 1'b1;
                ir_write        = mem_ready;
                pc_write        = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b       = SRCB_IMM_SH;
                alu_funct_force = 1'b1;
            end
            ST_R_EXEC: alu_src_a = 1'b1;
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                alu_src_a       = 1'b1;
                alu_src_b       = SRCB_IMM;
                alu_funct_force = 1'b1;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_LD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            ST_ADDI_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule
